// File: rtl/uart_rcvr_fifo.sv
// uart_rcvr_fifo: parametrised UART receiver feeding a show-ahead character FIFO.
// Each FIFO entry carries the received character together with its framing and
// parity error flags; a sticky overrun flag records characters lost to a full FIFO.
module uart_rcvr_fifo #(
    parameter int CLKS_PER_BIT = 54,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 uart_rx,
    input  logic                 rd_en,
    output logic                 rd_valid,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 rd_frame_err,
    output logic                 rd_parity_err,
    output logic                 overrun,
    input  logic                 clr_overrun
);

    localparam int CNT_W   = $clog2(CLKS_PER_BIT + 1);
    localparam int BIT_W   = $clog2(DATA_BITS);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = DATA_BITS + 2;

    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BREAK} state_t;

    state_t state_q, state_d;

    logic rxMeta_q, rxSync_q, rxPrev_q;
    logic fallEdge, tick, lastData, lastStop, push;

    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bitIdx_q, bitIdx_d;
    logic                 stopIdx_q, stopIdx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 frameErr_q, frameErr_d;
    logic                 parErr_q, parErr_d;

    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [ENTRY_W-1:0] pushEntry, headEntry;
    logic [PTR_W-1:0]   wrPtr_q, rdPtr_q;
    logic [PTR_W:0]     count_q, count_d;
    logic               overrun_q;
    logic               full, pop, doWrite, dropChar;

    // Two-flop synchroniser plus one extra stage remembering the previous synchronised sample
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rxMeta_q <= 1'b1;
            rxSync_q <= 1'b1;
            rxPrev_q <= 1'b1;
        end else begin
            rxMeta_q <= uart_rx;
            rxSync_q <= rxMeta_q;
            rxPrev_q <= rxSync_q;
        end
    end

    assign fallEdge = rxPrev_q & ~rxSync_q;
    assign tick     = (cnt_q == CNT_W'(1));
    assign lastData = (bitIdx_q == BIT_W'(DATA_BITS - 1));
    assign lastStop = (stopIdx_q == 1'(STOP_BITS - 1));

    // FSM state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; every sampling decision happens on a counter tick
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fallEdge) state_d = START;
            START:   if (tick) state_d = rxSync_q ? IDLE : DATA;
            DATA:    if (tick && lastData) state_d = (PARITY != 0) ? PAR : STOP;
            PAR:     if (tick) state_d = STOP;
            STOP:    if (tick && lastStop) state_d = rxSync_q ? IDLE : BREAK;
            BREAK:   if (rxSync_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM output logic: the final stop sample pushes one entry into the FIFO
    always_comb begin
        push      = (state_q == STOP) && tick && lastStop;
        pushEntry = {shift_q, frameErr_q | ~rxSync_q, parErr_q};
    end

    // Receive datapath next-state: bit timer, bit/stop counters, shift register, error flags
    always_comb begin
        cnt_d      = cnt_q;
        bitIdx_d   = bitIdx_q;
        stopIdx_d  = stopIdx_q;
        shift_d    = shift_q;
        frameErr_d = frameErr_q;
        parErr_d   = parErr_q;
        case (state_q)
            IDLE: begin
                if (fallEdge) begin
                    cnt_d      = HALF_BIT;
                    bitIdx_d   = '0;
                    stopIdx_d  = 1'b0;
                    frameErr_d = 1'b0;
                    parErr_d   = 1'b0;
                end
            end
            START, DATA, PAR, STOP: begin
                cnt_d = tick ? FULL_BIT : cnt_q - CNT_W'(1);
                if (tick && state_q == DATA) begin
                    shift_d  = {rxSync_q, shift_q[DATA_BITS-1:1]};
                    bitIdx_d = bitIdx_q + BIT_W'(1);
                end
                if (tick && state_q == PAR) begin
                    parErr_d = (PARITY == 1) ? ~(^shift_q ^ rxSync_q) : (^shift_q ^ rxSync_q);
                end
                if (tick && state_q == STOP) begin
                    stopIdx_d = stopIdx_q + 1'b1;
                    if (!rxSync_q) frameErr_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Receive datapath registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            bitIdx_q   <= '0;
            stopIdx_q  <= 1'b0;
            shift_q    <= '0;
            frameErr_q <= 1'b0;
            parErr_q   <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            bitIdx_q   <= bitIdx_d;
            stopIdx_q  <= stopIdx_d;
            shift_q    <= shift_d;
            frameErr_q <= frameErr_d;
            parErr_q   <= parErr_d;
        end
    end

    // A push into a full FIFO still lands when the head is popped in the same cycle,
    // because the write slot is exactly the slot being vacated
    assign full     = (count_q == (PTR_W + 1)'(FIFO_DEPTH));
    assign pop      = rd_en & rd_valid;
    assign doWrite  = push & (~full | pop);
    assign dropChar = push & full & ~pop;

    // FIFO occupancy update
    always_comb begin
        count_d = count_q;
        case ({doWrite, pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage; contents need no reset since outputs are gated by rd_valid
    always_ff @(posedge clock) begin
        if (doWrite) mem[wrPtr_q] <= pushEntry;
    end

    // FIFO pointers, occupancy and sticky overrun flag (set beats clear)
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (doWrite) wrPtr_q <= wrPtr_q + PTR_W'(1);
            if (pop)     rdPtr_q <= rdPtr_q + PTR_W'(1);
            count_q <= count_d;
            if (dropChar) overrun_q <= 1'b1;
            else if (clr_overrun) overrun_q <= 1'b0;
        end
    end

    // Show-ahead read port, forced to zero while the FIFO is empty
    always_comb begin
        headEntry     = mem[rdPtr_q];
        rd_valid      = (count_q != '0);
        rd_data       = rd_valid ? headEntry[ENTRY_W-1:2] : '0;
        rd_frame_err  = rd_valid & headEntry[1];
        rd_parity_err = rd_valid & headEntry[0] & (PARITY != 0);
        overrun       = overrun_q;
    end

endmodule

// File: tb/tb_uart_rcvr_fifo.sv
// tb_uart_rcvr_fifo: directed bench for uart_rcvr_fifo.
// dutA runs the default 8N1 configuration at 54 clocks per bit; dutB runs
// 7 data bits, even parity, two stop bits at 16 clocks per bit.
module tb_uart_rcvr_fifo;

    logic       clock;
    logic       reset_n;
    logic       rxA, rxB;
    logic       rdEnA, rdEnB;
    logic       clrA, clrB;
    logic       validA, validB;
    logic [7:0] dataA;
    logic [6:0] dataB;
    logic       frameA, frameB, parA, parB, ovrA, ovrB;

    int checks = 0;
    int errors = 0;

    uart_rcvr_fifo dutA (
        .clock(clock), .reset_n(reset_n), .uart_rx(rxA), .rd_en(rdEnA),
        .rd_valid(validA), .rd_data(dataA), .rd_frame_err(frameA),
        .rd_parity_err(parA), .overrun(ovrA), .clr_overrun(clrA)
    );

    uart_rcvr_fifo #(
        .CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)
    ) dutB (
        .clock(clock), .reset_n(reset_n), .uart_rx(rxB), .rd_en(rdEnB),
        .rd_valid(validB), .rd_data(dataB), .rd_frame_err(frameB),
        .rd_parity_err(parB), .overrun(ovrB), .clr_overrun(clrB)
    );

    // Free-running 100 MHz clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Compare one observed value against its hand-computed expectation
    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive a complete bit sequence LSB first on the selected line; the line is left at the last bit
    task automatic applyStimulus(input int sel, input logic [15:0] frame, input int nbits, input int cpb);
        for (int i = 0; i < nbits; i++) begin
            if (sel == 0) rxA = frame[i];
            else          rxB = frame[i];
            repeat (cpb) @(posedge clock);
            #1;
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic popA();
        rdEnA = 1'b1;
        @(posedge clock);
        #1;
        rdEnA = 1'b0;
    endtask

    task automatic popB();
        rdEnB = 1'b1;
        @(posedge clock);
        #1;
        rdEnB = 1'b0;
    endtask

    // Directed sequence
    initial begin
        reset_n = 1'b0;
        rxA = 1'b1; rxB = 1'b1;
        rdEnA = 1'b0; rdEnB = 1'b0;
        clrA = 1'b0; clrB = 1'b0;
        waitCycles(3);
        checkOutput("reset_valid", 16'(validA), 16'h0);
        checkOutput("reset_data", 16'(dataA), 16'h0);
        checkOutput("reset_frame", 16'(frameA), 16'h0);
        checkOutput("reset_par", 16'(parA), 16'h0);
        checkOutput("reset_ovr", 16'(ovrA), 16'h0);
        checkOutput("reset_validB", 16'(validB), 16'h0);
        reset_n = 1'b1;
        waitCycles(5);

        // dutB: 0x41 with correct even parity bit 0
        applyStimulus(1, 16'({2'b11, 1'b0, 7'h41, 1'b0}), 11, 16);
        waitCycles(4);
        checkOutput("b41_valid", 16'(validB), 16'h1);
        checkOutput("b41_data", 16'(dataB), 16'h41);
        checkOutput("b41_par", 16'(parB), 16'h0);
        checkOutput("b41_frame", 16'(frameB), 16'h0);
        popB();
        // dutB: 0x41 with wrong parity bit 1
        applyStimulus(1, 16'({2'b11, 1'b1, 7'h41, 1'b0}), 11, 16);
        waitCycles(4);
        checkOutput("b41bad_data", 16'(dataB), 16'h41);
        checkOutput("b41bad_par", 16'(parB), 16'h1);
        popB();
        // dutB: 0x07 (odd count of ones) with parity 1, first stop low, second high
        applyStimulus(1, 16'({1'b1, 1'b0, 1'b1, 7'h07, 1'b0}), 11, 16);
        waitCycles(4);
        checkOutput("b07_data", 16'(dataB), 16'h07);
        checkOutput("b07_par", 16'(parB), 16'h0);
        checkOutput("b07_frame", 16'(frameB), 16'h1);
        popB();
        checkOutput("b_empty", 16'(validB), 16'h0);

        // dutA: two clean characters
        applyStimulus(0, 16'({1'b1, 8'hAB, 1'b0}), 10, 54);
        waitCycles(10);
        applyStimulus(0, 16'({1'b1, 8'hDE, 1'b0}), 10, 54);
        waitCycles(5);
        checkOutput("ab_data", 16'(dataA), 16'hAB);
        checkOutput("ab_frame", 16'(frameA), 16'h0);
        checkOutput("ab_par", 16'(parA), 16'h0);
        popA();
        checkOutput("de_data", 16'(dataA), 16'hDE);
        checkOutput("de_frame", 16'(frameA), 16'h0);
        checkOutput("de_ovr", 16'(ovrA), 16'h0);
        popA();
        checkOutput("ab_de_empty", 16'(validA), 16'h0);

        // dutA: stop bit held low, line stays low (break)
        applyStimulus(0, 16'({1'b0, 8'h55, 1'b0}), 10, 54);
        waitCycles(300);
        rxA = 1'b1;
        waitCycles(20);
        checkOutput("brk_data", 16'(dataA), 16'h55);
        checkOutput("brk_frame", 16'(frameA), 16'h1);
        popA();
        checkOutput("brk_single", 16'(validA), 16'h0);
        applyStimulus(0, 16'({1'b1, 8'h12, 1'b0}), 10, 54);
        waitCycles(5);
        checkOutput("post_brk_data", 16'(dataA), 16'h12);
        checkOutput("post_brk_frame", 16'(frameA), 16'h0);
        popA();

        // dutA: 10-cycle glitch is rejected
        rxA = 1'b0;
        waitCycles(10);
        rxA = 1'b1;
        waitCycles(100);
        checkOutput("glitch_nopush", 16'(validA), 16'h0);
        applyStimulus(0, 16'({1'b1, 8'h3C, 1'b0}), 10, 54);
        waitCycles(5);
        checkOutput("glitch_next", 16'(dataA), 16'h3C);
        popA();

        // dutA: five characters into a four-entry FIFO
        for (int i = 1; i <= 5; i++) applyStimulus(0, 16'({1'b1, 8'(i), 1'b0}), 10, 54);
        waitCycles(5);
        checkOutput("ovr_set", 16'(ovrA), 16'h1);
        for (int i = 1; i <= 4; i++) begin
            checkOutput($sformatf("ovr_entry%0d", i), 16'(dataA), 16'(i));
            popA();
        end
        checkOutput("ovr_drained", 16'(validA), 16'h0);
        checkOutput("ovr_sticky", 16'(ovrA), 16'h1);
        clrA = 1'b1;
        waitCycles(1);
        clrA = 1'b0;
        checkOutput("ovr_cleared", 16'(ovrA), 16'h0);

        // dutA: fill, then pop in exactly the cycle of the fifth push
        for (int i = 0; i < 4; i++) applyStimulus(0, 16'({1'b1, 8'(8'h11 + i), 1'b0}), 10, 54);
        waitCycles(5);
        checkOutput("fill_ovr", 16'(ovrA), 16'h0);
        fork
            applyStimulus(0, 16'({1'b1, 8'h15, 1'b0}), 10, 54);
            begin
                repeat (515) @(posedge clock);
                #1;
                rdEnA = 1'b1;
                @(posedge clock);
                #1;
                rdEnA = 1'b0;
            end
        join
        checkOutput("pushpop_ovr", 16'(ovrA), 16'h0);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("pushpop_entry%0d", i), 16'(dataA), 16'(8'h12 + i));
            popA();
        end
        checkOutput("pushpop_last", 16'(dataA), 16'h15);
        checkOutput("pre_rst_valid", 16'(validA), 16'h1);

        // dutA: asynchronous reset in the middle of data bit 3
        fork
            applyStimulus(0, 16'({1'b1, 8'hAB, 1'b0}), 10, 54);
            begin
                repeat (4 * 54 + 27) @(posedge clock);
                #1;
                reset_n = 1'b0;
                #1;
                checkOutput("rst_valid", 16'(validA), 16'h0);
                checkOutput("rst_data", 16'(dataA), 16'h0);
                checkOutput("rst_ovr", 16'(ovrA), 16'h0);
            end
        join
        waitCycles(3);
        reset_n = 1'b1;
        waitCycles(20);
        checkOutput("rst_nopush", 16'(validA), 16'h0);
        applyStimulus(0, 16'({1'b1, 8'hCD, 1'b0}), 10, 54);
        waitCycles(5);
        checkOutput("post_rst_data", 16'(dataA), 16'hCD);
        checkOutput("post_rst_frame", 16'(frameA), 16'h0);
        popA();
        checkOutput("final_empty", 16'(validA), 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rcvr_fifo.md
# uart_rcvr_fifo

Parametrised UART receiver with a character FIFO, and the successor to the fixed 8N1 receiver. It supports configurable bit period, data width, parity mode and stop-bit count. It reports framing and parity errors per character and flags FIFO overrun. It sits between the board RX pin and the image/command loader, which drains characters through a show-ahead read port.

## Interface
- CLKS_PER_BIT, 54, clock cycles per bit period; must be ≥ 4.
- DATA_BITS, 8, data bits per character, 5..9, LSB first on the line.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits per character, 1 or 2.
- FIFO_DEPTH, 4, entries; power of two, ≥ 2.

- clock  input  1  system clock, all logic on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- uart_rx  input  1  serial line, idle high, asynchronous to clock.
- rd_en  input  1  pop request; honoured only when rd_valid = 1.
- rd_valid  output  1  FIFO non-empty; rd_data, rd_frame_err and rd_parity_err describe the head entry.
- rd_data  output  DATA_BITS  head character.
- rd_frame_err  output  1  head character had a low stop-bit sample.
- rd_parity_err  output  1  head character failed parity; always 0 when PARITY = 0.
- overrun  output  1  sticky: a completed character was dropped because the FIFO was full.
- clr_overrun  input  1  synchronous clear of overrun.

## Operation
- uart_rx passes through a 2-flop synchroniser (line reset value 1); all decisions use the synchronised value rx_s.
- FSM states are IDLE, START, DATA, PAR, STOP, BREAK.
- IDLE: on rx_s falling edge (previous sample 1, current 0), load the bit counter with CLKS_PER_BIT/2 (integer division) and go to START.
- START: at the mid-bit sample, if rx_s = 1 it is a glitch: return to IDLE with no push. Otherwise go to DATA with the bit counter reloaded to CLKS_PER_BIT.
- DATA: sample once per CLKS_PER_BIT into the shift register, LSB first. After DATA_BITS samples go to PAR if PARITY ≠ 0, else to STOP.
- PAR: sample one bit. The parity error is set when the XOR of the data bits and the parity bit is 0 (odd mode) or 1 (even mode).
- STOP: sample STOP_BITS bits. Any low sample sets the frame error.
- At the final stop sample, push {data, frame_err, parity_err} into the FIFO.
  - If the final stop sample is 1, next state is IDLE.
  - If it is 0, next state is BREAK.
- BREAK: wait until rx_s = 1, then go to IDLE. No further pushes occur during a held-low line.
- FIFO is a circular buffer with wrapping read and write pointers and an occupancy count.
  - Pop occurs when rd_en & rd_valid.
  - rd_en while empty is ignored.
  - Push and pop in the same cycle are both performed, including when full; this is not an overrun.
  - Push when full without pop: the character is dropped, FIFO is unchanged, overrun is set.
  - If overrun is set and clr_overrun is high in the same cycle, set wins.
- Reset (reset_n = 0), immediate and asynchronous:
  - FSM returns to IDLE, synchroniser flops to 1, FIFO empties.
  - rd_valid = 0, rd_data = 0, rd_frame_err = 0, rd_parity_err = 0, overrun = 0.
  - A frame in progress is discarded. Reception resumes at the next falling edge after reset release.

## Timing
- Define t0 as the cycle the FSM detects the falling edge on rx_s, which is 2–3 cycles after the uart_rx edge.
- Start sample at t0 + CLKS_PER_BIT/2.
- Bit k sample at t0 + CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT, for k = 0 through DATA_BITS−1, then the parity bit and stop bits in the same cadence.
- Push occurs on the clock edge of the last stop sample. rd_valid is high and rd_data is valid from that edge.
- After a pop edge, the next entry, or rd_valid = 0, is visible immediately.
- Back-to-back frames are supported: a start edge may be detected in IDLE the cycle after the last stop sample.
- Throughput is one character per frame time. Read throughput is one pop per cycle.

## Test plan
- Default 8N1, CLKS_PER_BIT = 54: send 0xAB, then 0xDE after 10 idle cycles → rd_data = 0xAB then 0xDE, both error flags 0, overrun = 0.
- PARITY = 2, DATA_BITS = 7:
  - Send 0x41 with correct parity bit 0 → parity_err = 0.
  - Resend 0x41 with parity bit 1 → rd_data = 0x41, rd_parity_err = 1.
- Hold the stop bit low after 0x55 and keep the line low for 300 cycles → exactly one entry: 0x55 with rd_frame_err = 1. A following 0x12 is received cleanly.
- Glitch: uart_rx low for 10 cycles, then high → no push, FSM back in IDLE. A following 0x3C is received correctly.
- FIFO_DEPTH = 4: send 0x01..0x05 with no reads → entries 0x01..0x04, overrun = 1.
  - Pop all four → rd_valid = 0.
  - Pulse clr_overrun → overrun = 0.
  - rd_en pulsed while full in the cycle of a push → no overrun.
- Assert reset_n low mid-way through data bit 3 of 0xAB → all outputs 0 immediately, no entry pushed. Subsequent 0xCD is received correctly.
